// File: rtl/riscv_mule_seq_pkg.sv
// Shared definitions for the MULE multi-cycle multiply unit.
//   - operand/slice widths
//   - MULE_OP_* operation encodings (as carried on opcode_op_i)
//   - MULE_ST_* sequencer state encodings (also visible on the debug state port)
//   - custom opcode/funct match constants used by the instruction decoder
//   - small helpers for operand signedness and magnitude extraction
package riscv_mule_seq_pkg;

    localparam int XLEN   = 32;
    localparam int HALF_W = XLEN / 2;

    typedef enum logic [1:0] {
        MULE_OP_MUL    = 2'd0,  // low word of product
        MULE_OP_MULH   = 2'd1,  // high word, signed x signed
        MULE_OP_MULHSU = 2'd2,  // high word, signed x unsigned
        MULE_OP_MULHU  = 2'd3   // high word, unsigned x unsigned
    } mule_op_e;

    typedef enum logic [2:0] {
        MULE_ST_IDLE = 3'd0,
        MULE_ST_LL   = 3'd1,
        MULE_ST_LH   = 3'd2,
        MULE_ST_HL   = 3'd3,
        MULE_ST_HH   = 3'd4,
        MULE_ST_FIN  = 3'd5
    } mule_state_e;

    // Custom-0 major opcode; decoder matches these to route an instruction here.
    localparam logic [6:0] MULE_OPCODE = 7'b0001011;
    localparam logic [2:0] MULE_FUNCT3 = 3'b001;
    localparam logic [6:0] MULE_FUNCT7 = 7'b0000001;

    function automatic logic mule_match(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
        return (opcode == MULE_OPCODE) && (funct3 == MULE_FUNCT3) &&
               (funct7 == MULE_FUNCT7);
    endfunction

    function automatic logic op_a_signed(input mule_op_e op);
        return (op == MULE_OP_MULH) || (op == MULE_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input mule_op_e op);
        return (op == MULE_OP_MULH);
    endfunction

    // Two's-complement magnitude as an unsigned XLEN value. The most negative
    // value maps to itself, which is exactly its unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/riscv_mule_seq_mul16.sv
// Combinational 16x16 unsigned multiplier shared across the partial-product
// cycles of the MULE unit.
//   a       in  HALF_W      multiplicand slice
//   b       in  HALF_W      multiplier slice
//   product out 2*HALF_W    unsigned product
module riscv_mule_seq_mul16
    import riscv_mule_seq_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] product
);

    assign product = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};

endmodule

// File: rtl/riscv_mule_seq.sv
// MULE multi-cycle multiply execution unit.
// Builds a 32x32 product from four 16x16 partial products on one shared
// multiplier (LL, LH, HL, HH), then sign-fixes and returns the low or high
// word on a one-cycle writeback strobe.
//
// Handshake: an op is taken on a clock edge where opcode_valid_i is high,
// busy_o is low, and neither hold_i nor flush_i is asserted. Issue must not
// present a new op while busy_o is high; if it does the op is ignored.
// writeback_valid_o pulses for one cycle (longer only while hold_i is high).
//
// Ports
//   clk_i, rst_i              clock, async active-high reset
//   opcode_valid_i            op presented this cycle
//   opcode_op_i               MUL / MULH / MULHSU / MULHU
//   opcode_rd_idx_i           destination register
//   opcode_ra_operand_i       rs1 value
//   opcode_rb_operand_i       rs2 value
//   hold_i                    freezes all state
//   flush_i                   aborts the in-flight op (beats hold)
//   busy_o                    unit occupied (registered state only)
//   writeback_valid_o         result strobe
//   writeback_rd_idx_o        result destination
//   writeback_value_o         result value
//   dbg_state_o               current sequencer state
module riscv_mule_seq
    import riscv_mule_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            opcode_valid_i,
    input  logic [1:0]      opcode_op_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [31:0]     opcode_ra_operand_i,
    input  logic [31:0]     opcode_rb_operand_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            writeback_valid_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic [31:0]     writeback_value_o,
    output logic [2:0]      dbg_state_o
);

    mule_state_e state_q;
    mule_state_e state_d;

    mule_op_e          op_in;
    mule_op_e          op_q;
    logic              neg_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   p0_q;
    logic [XLEN:0]     p1_q;    // 33 bits: sum of two cross products keeps its carry
    logic [XLEN-1:0]   p2_q;

    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_value_q;

    logic              accept;
    logic              sign_a;
    logic              sign_b;
    logic [HALF_W-1:0] mul_a;
    logic [HALF_W-1:0] mul_b;
    logic [XLEN-1:0]   mul_p;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   result;

    assign op_in  = mule_op_e'(opcode_op_i);
    assign accept = opcode_valid_i && (state_q == MULE_ST_IDLE) && !hold_i && !flush_i;
    assign sign_a = op_a_signed(op_in) && opcode_ra_operand_i[XLEN-1];
    assign sign_b = op_b_signed(op_in) && opcode_rb_operand_i[XLEN-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MULE_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = MULE_ST_IDLE;
        end else if (!hold_i) begin
            case (state_q)
                MULE_ST_IDLE: if (accept) state_d = MULE_ST_LL;
                MULE_ST_LL:   state_d = MULE_ST_LH;
                MULE_ST_LH:   state_d = MULE_ST_HL;
                MULE_ST_HL:   state_d = MULE_ST_HH;
                MULE_ST_HH:   state_d = MULE_ST_FIN;
                MULE_ST_FIN:  state_d = MULE_ST_IDLE;
                default:      state_d = MULE_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (busy and shared-multiplier operand select)
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = (state_q != MULE_ST_IDLE);
        mul_a  = a_q[HALF_W-1:0];
        mul_b  = b_q[HALF_W-1:0];
        case (state_q)
            MULE_ST_LH: begin
                mul_b = b_q[XLEN-1:HALF_W];
            end
            MULE_ST_HL: begin
                mul_a = a_q[XLEN-1:HALF_W];
            end
            MULE_ST_HH: begin
                mul_a = a_q[XLEN-1:HALF_W];
                mul_b = b_q[XLEN-1:HALF_W];
            end
            default: ;
        endcase
    end

    riscv_mule_seq_mul16 u_mul16 (
        .a       (mul_a),
        .b       (mul_b),
        .product (mul_p)
    );

    // ------------------------------------------------------------------
    // Operand capture and partial-product accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            p0_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            neg_q <= 1'b0;
            op_q  <= MULE_OP_MUL;
            rd_q  <= '0;
        end else if (!flush_i && !hold_i) begin
            if (accept) begin
                a_q   <= magnitude(opcode_ra_operand_i, op_a_signed(op_in));
                b_q   <= magnitude(opcode_rb_operand_i, op_b_signed(op_in));
                neg_q <= sign_a ^ sign_b;
                op_q  <= op_in;
                rd_q  <= opcode_rd_idx_i;
            end
            case (state_q)
                MULE_ST_LL: p0_q <= mul_p;
                MULE_ST_LH: p1_q <= {1'b0, mul_p};
                MULE_ST_HL: p1_q <= p1_q + {1'b0, mul_p};
                MULE_ST_HH: p2_q <= mul_p;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Final combine: magnitude product, sign fixup, word select
    // ------------------------------------------------------------------
    always_comb begin
        prod_mag = {{XLEN{1'b0}}, p0_q}
                 + {{(XLEN-HALF_W-1){1'b0}}, p1_q, {HALF_W{1'b0}}}
                 + {p2_q, {XLEN{1'b0}}};
        prod     = neg_q ? (~prod_mag + 64'd1) : prod_mag;
        result   = (op_q == MULE_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // Writeback registers. A flush kills the strobe even if FIN is
    // completing this very cycle; hold keeps the strobe and data frozen.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_value_q <= '0;
        end else if (flush_i) begin
            wb_valid_q <= 1'b0;
        end else if (!hold_i) begin
            wb_valid_q <= (state_q == MULE_ST_FIN);
            if (state_q == MULE_ST_FIN) begin
                wb_rd_q    <= rd_q;
                wb_value_q <= result;
            end
        end
    end

    assign writeback_valid_o  = wb_valid_q;
    assign writeback_rd_idx_o = wb_rd_q;
    assign writeback_value_o  = wb_value_q;
    assign dbg_state_o        = state_q;

endmodule
